mc_ctrl_wait: RTL and testbench
===============================

Name: mc_ctrl_wait

Overview:
- Next-generation multicycle MIPS control unit for the single-issue datapath. It drives the same datapath strobes as the current controller (PC, IR, register file, ALU, extender, data memory).
- New over the current controller:
  - variable-latency instruction and data memory handshakes;
  - bus-timeout detection;
  - an illegal-opcode trap state;
  - parametrised cycle and retired-instruction counters.

Parameters:
- CNT_W, 32, width of cycle_cnt and retired_cnt; both wrap modulo 2^CNT_W.
- WAIT_TIMEOUT, 16, maximum consecutive wait cycles in a memory state before a bus-timeout trap; 0 disables the timeout.
- TRAP_ON_ILLEGAL, 1, 1: an unknown opcode enters TRAP; 0: an unknown opcode returns to FETCH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr  in  32  current instruction register contents. opcode = instr[31:26], func = instr[5:0].
- zero  in  1  ALU zero flag.
- imem_ready  in  1  instruction memory read complete this cycle.
- dmem_ready  in  1  data memory access complete this cycle.
- regdst  out  2  01: I-type rt destination; 10: jal ($31); 00: rd.
- write_sel  out  2  00: ALU result; 01: memory (lw/lb/sw/sb); 11: slt; 10: jal link.
- pc_sel  out  2  00: PC+4; 01: beq target; 10: j/jal target; 11: jr. Forced to 00 in FETCH.
- aluctr  out  2  01: subu/slt/beq; 10: ori; 00: add.
- alusrc  out  1  immediate operand for ori, lw, sw, lb, sb, lui, addi, addiu.
- extop  out  2  01: sign-extend (addi, addiu, beq, lw, sw, lb, sb); 10: lui; 00: zero-extend.
- addi_ovf  out  1  instruction is addi; enables overflow check.
- lb_sel  out  1  instruction is lb.
- sb_sel  out  1  instruction is sb.
- irwr  out  1  IR write strobe.
- pcwr  out  1  PC write strobe.
- rf_we  out  1  register file write strobe.
- mem_rd  out  1  data memory read request.
- memwr  out  1  data memory write request.
- trap  out  1  controller halted in TRAP.
- trap_cause  out  2  00: none; 01: illegal opcode; 10: bus timeout.
- state  out  4  current state, registered.
- cycle_cnt  out  CNT_W  cycles elapsed outside TRAP.
- retired_cnt  out  CNT_W  instructions completed.

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5;
  - EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9, TRAP=10.
  - Encodings 11-15 go to FETCH on the next clock.
- Supported instructions: addu, subu, slt, jr, ori, lui, addi, addiu, beq, j, jal, lw, sw, lb, sb. Any other opcode/func is illegal.
- Decode outputs (regdst, write_sel, pc_sel, aluctr, alusrc, extop, addi_ovf, lb_sel, sb_sel) are combinational from instr and are don't-care in FETCH.
- Reset (rst=0, asynchronous):
  - state=FETCH, trap_cause=00, counters=0, wait counter=0.
  - While rst=0, irwr, pcwr, rf_we, mem_rd and memwr are forced to 0.
- FETCH:
  - irwr = pcwr = imem_ready.
  - imem_ready=1: go to DECODE. Otherwise stay and increment the wait counter.
- DECODE:
  - lw/sw/lb/sb -> MEM_ADDR.
  - addu/subu/slt/ori/lui/addi/addiu -> EXEC.
  - beq/jr -> BRANCH.
  - j/jal -> JUMP.
  - Illegal -> TRAP with cause 01 (TRAP_ON_ILLEGAL=1), or FETCH (TRAP_ON_ILLEGAL=0).
- MEM_ADDR: loads -> MEM_READ; stores -> MEM_WRITE.
- MEM_READ:
  - mem_rd=1 throughout.
  - dmem_ready -> MEM_WB; otherwise stay and count wait cycles.
- MEM_WB: rf_we=1, then FETCH.
- MEM_WRITE:
  - memwr=1 and held until dmem_ready.
  - dmem_ready -> FETCH.
- EXEC: go to ALU_WB.
- ALU_WB: rf_we=1, then FETCH.
- BRANCH: pcwr = (beq & zero) | jr, then FETCH.
- JUMP: pcwr=1; rf_we = jal. Then FETCH.
- Wait counter:
  - Cleared on every state change.
  - If WAIT_TIMEOUT>0 and the counter reaches WAIT_TIMEOUT in FETCH, MEM_READ or MEM_WRITE with ready still 0, the next state is TRAP with cause 10.
  - A ready that arrives in the same cycle the counter reaches the limit wins: no trap.
- TRAP:
  - Sticky until reset. trap=1, all strobes 0, counters frozen.
  - trap_cause is written once, on entry.
- cycle_cnt increments on every clock outside reset and TRAP.
- retired_cnt increments on the final cycle of each instruction:
  - MEM_WB, ALU_WB, BRANCH, JUMP;
  - MEM_WRITE with dmem_ready=1.
- Illegal instructions are not counted as retired.
- Latency with ready=1 at first request:
  - ALU ops: 4 cycles.
  - lw/lb: 5 cycles.
  - sw/sb: 4 cycles.
  - beq/jr/j/jal: 3 cycles.
- Reset asserted mid-instruction aborts it immediately. No strobe fires after rst falls.

Test Plan:
- addu with imem_ready=1 -> states 0,1,6,7,0; rf_we high only in state 7; retired_cnt 0->1; cycle_cnt=4.
- lw with dmem_ready low for 3 cycles -> mem_rd high 4 cycles in MEM_READ; rf_we one cycle in MEM_WB; total 8 cycles.
- beq with zero=1, then zero=0 -> pcwr=1 with pc_sel=01 in BRANCH for the first; pcwr=0 in BRANCH for the second; both retire.
- opcode 6'b111111 (TRAP_ON_ILLEGAL=1) -> TRAP after DECODE, trap=1, trap_cause=01, counters frozen. rst low then high -> FETCH, cause 00.
- sw with dmem_ready stuck low, WAIT_TIMEOUT=4 -> memwr held; TRAP with cause 10 after 4 wait cycles. Same scenario with ready on the 4th cycle -> FETCH, no trap.
- jal, then rst pulsed low during MEM_READ of a following lw -> rf_we=1, regdst=10, write_sel=10 in JUMP. Immediately on rst low: state=0, mem_rd=0.

Source files
------------

// File: rtl/mc_ctrl_wait.sv
// mc_ctrl_wait: multicycle MIPS control unit with variable-latency memory handshakes,
// bus-timeout and illegal-opcode traps, and cycle/retired-instruction counters.
module mc_ctrl_wait #(
    parameter int CNT_W           = 32,
    parameter int WAIT_TIMEOUT    = 16,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic [1:0]       regdst,
    output logic [1:0]       write_sel,
    output logic [1:0]       pc_sel,
    output logic [1:0]       aluctr,
    output logic             alusrc,
    output logic [1:0]       extop,
    output logic             addi_ovf,
    output logic             lb_sel,
    output logic             sb_sel,
    output logic             irwr,
    output logic             pcwr,
    output logic             rf_we,
    output logic             mem_rd,
    output logic             memwr,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
        EXEC, ALU_WB, BRANCH, JUMP, TRAP
    } state_t;
    localparam int WW = WAIT_TIMEOUT > 0 ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] LIM = WW'(WAIT_TIMEOUT > 0 ? WAIT_TIMEOUT - 1 : 0);
    state_t cur, nxt;
    logic [WW-1:0] wcnt;
    logic [5:0] op, fn;
    logic rt, addu, subu, slt, jr, ori, lui, addi, addiu, beq, j, jal, lw, sw, lb, sb;
    logic ld, mem, alu, waiting, timeout, retire, unused_bits;
    assign op          = instr[31:26];
    assign fn          = instr[5:0];
    assign unused_bits = ^instr[25:6];
    assign rt    = op == 6'h00;
    assign addu  = rt && fn == 6'h21;
    assign subu  = rt && fn == 6'h23;
    assign slt   = rt && fn == 6'h2a;
    assign jr    = rt && fn == 6'h08;
    assign ori   = op == 6'h0d;
    assign lui   = op == 6'h0f;
    assign addi  = op == 6'h08;
    assign addiu = op == 6'h09;
    assign beq   = op == 6'h04;
    assign j     = op == 6'h02;
    assign jal   = op == 6'h03;
    assign lw    = op == 6'h23;
    assign sw    = op == 6'h2b;
    assign lb    = op == 6'h20;
    assign sb    = op == 6'h28;
    assign ld    = lw | lb;
    assign mem   = lw | sw | lb | sb;
    assign alu   = addu | subu | slt | ori | lui | addi | addiu;
    assign regdst    = jal ? 2'b10 : (ori | lui | addi | addiu | ld) ? 2'b01 : 2'b00;
    assign write_sel = mem ? 2'b01 : slt ? 2'b11 : jal ? 2'b10 : 2'b00;
    assign pc_sel    = cur == FETCH ? 2'b00 : beq ? 2'b01 : (j | jal) ? 2'b10 : jr ? 2'b11 : 2'b00;
    assign aluctr    = (subu | slt | beq) ? 2'b01 : ori ? 2'b10 : 2'b00;
    assign alusrc    = ori | lui | addi | addiu | mem;
    assign extop     = lui ? 2'b10 : (addi | addiu | beq | mem) ? 2'b01 : 2'b00;
    assign addi_ovf  = addi;
    assign lb_sel    = lb;
    assign sb_sel    = sb;
    // A ready arriving on the limit cycle clears waiting, so it beats the timeout.
    assign waiting = (cur == FETCH && !imem_ready) || ((cur == MEM_READ || cur == MEM_WRITE) && !dmem_ready);
    assign timeout = WAIT_TIMEOUT > 0 && waiting && wcnt == LIM;
    assign retire  = cur == MEM_WB || cur == ALU_WB || cur == BRANCH || cur == JUMP || (cur == MEM_WRITE && dmem_ready);
    assign irwr   = rst && cur == FETCH && imem_ready;
    assign pcwr   = rst && ((cur == FETCH && imem_ready) || (cur == BRANCH && ((beq && zero) || jr)) || cur == JUMP);
    assign rf_we  = rst && (cur == MEM_WB || cur == ALU_WB || (cur == JUMP && jal));
    assign mem_rd = rst && cur == MEM_READ;
    assign memwr  = rst && cur == MEM_WRITE;
    assign trap   = cur == TRAP;
    assign state  = cur;
    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:     nxt = timeout ? TRAP : imem_ready ? DECODE : FETCH;
            DECODE:    nxt = mem ? MEM_ADDR : alu ? EXEC : (beq | jr) ? BRANCH : (j | jal) ? JUMP : TRAP_ON_ILLEGAL ? TRAP : FETCH;
            MEM_ADDR:  nxt = ld ? MEM_READ : MEM_WRITE;
            MEM_READ:  nxt = timeout ? TRAP : dmem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE: nxt = timeout ? TRAP : dmem_ready ? FETCH : MEM_WRITE;
            EXEC:      nxt = ALU_WB;
            TRAP:      nxt = TRAP;
            default:   nxt = FETCH;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur         <= FETCH;
            wcnt        <= '0;
            trap_cause  <= 2'b00;
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            cur  <= nxt;
            wcnt <= (nxt != cur || cur == TRAP) ? '0 : wcnt + 1'b1;
            if (nxt == TRAP && cur != TRAP)
                trap_cause <= cur == DECODE ? 2'b01 : 2'b10;
            if (cur != TRAP)
                cycle_cnt <= cycle_cnt + 1'b1;
            if (retire)
                retired_cnt <= retired_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mc_ctrl_wait.sv
// tb_mc_ctrl_wait: table-driven decode/latency vectors plus hand-written wait, timeout,
// illegal-opcode and mid-instruction reset sequences for mc_ctrl_wait.
module tb_mc_ctrl_wait;
    logic        clk = 1'b0, rst = 1'b0, zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [1:0]  regdst, write_sel, pc_sel, aluctr, extop, trap_cause;
    logic        alusrc, addi_ovf, lb_sel, sb_sel, irwr, pcwr, rf_we, mem_rd, memwr, trap;
    logic [3:0]  state;
    logic [31:0] cycle_cnt, retired_cnt;
    int checks = 0, passed = 0, exp_cyc = 0, exp_ret = 0;

    typedef struct {
        logic [31:0] i;
        logic        z;
        logic [13:0] dec;
        int          s2;
        int          lat;
        logic [15:0] stb;
    } vec_t;
    vec_t tbl[16];

    always #5 clk = ~clk;

    mc_ctrl_wait #(.CNT_W(32), .WAIT_TIMEOUT(4), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .regdst(regdst), .write_sel(write_sel), .pc_sel(pc_sel),
        .aluctr(aluctr), .alusrc(alusrc), .extop(extop), .addi_ovf(addi_ovf), .lb_sel(lb_sel),
        .sb_sel(sb_sel), .irwr(irwr), .pcwr(pcwr), .rf_we(rf_we), .mem_rd(mem_rd), .memwr(memwr),
        .trap(trap), .trap_cause(trap_cause), .state(state), .cycle_cnt(cycle_cnt),
        .retired_cnt(retired_cnt)
    );

    function automatic logic [31:0] mk(input int op, input int fn);
        return {6'(op), 20'd0, 6'(fn)};
    endfunction

    function automatic logic [13:0] d(input int rd, input int ws, input int pc, input int al,
                                      input int src, input int ext, input int ovf, input int lb, input int sb);
        return {2'(rd), 2'(ws), 2'(pc), 2'(al), 1'(src), 2'(ext), 1'(ovf), 1'(lb), 1'(sb)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Runs one instruction from FETCH; dmem_ready stays low for the first dw memory-state cycles.
    task automatic run_seq(input logic [31:0] i, input logic z, input int dw, output int n,
                           output logic [15:0] stb, output logic [13:0] dec, output int s2);
        int w = 0, nrf = 0, npc = 0, nrd = 0, nwr = 0;
        n = 0;
        dec = '0;
        s2 = 0;
        instr = i;
        zero = z;
        imem_ready = 1'b1;
        do begin
            dmem_ready = (state == 4'd3 || state == 4'd5) && w >= dw;
            if (state == 4'd3 || state == 4'd5) w++;
            #1;
            if (n == 1) dec = {regdst, write_sel, pc_sel, aluctr, alusrc, extop, addi_ovf, lb_sel, sb_sel};
            if (n == 2) s2 = int'(state);
            nrf += int'(rf_we);
            npc += int'(pcwr);
            nrd += int'(mem_rd);
            nwr += int'(memwr);
            n++;
            @(negedge clk);
        end while (state != 4'd0 && state != 4'd10 && n < 40);
        stb = {4'(nrf), 4'(npc), 4'(nrd), 4'(nwr)};
    endtask

    task automatic trap_then_reset(input string tag, input logic [1:0] cause);
        check({tag, "_state"}, state, 4'd10);
        check({tag, "_trap"}, trap, 1'b1);
        check({tag, "_cause"}, trap_cause, cause);
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_frz_cyc"}, cycle_cnt, exp_cyc);
        check({tag, "_frz_ret"}, retired_cnt, exp_ret);
        check({tag, "_frz_stb"}, {irwr, pcwr, rf_we, mem_rd, memwr}, 5'b0);
        check({tag, "_frz_cause"}, trap_cause, cause);
        rst = 1'b0;
        #1;
        check({tag, "_rst_state"}, state, 4'd0);
        check({tag, "_rst_cause"}, trap_cause, 2'b00);
        check({tag, "_rst_cyc"}, cycle_cnt, 0);
        check({tag, "_rst_trap"}, trap, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        exp_cyc = 0;
        exp_ret = 0;
    endtask

    initial begin
        int n, s2;
        logic [15:0] stb;
        logic [13:0] dec;
        tbl[0]  = '{mk(6'h00, 6'h21), 1'b0, d(0, 0, 0, 0, 0, 0, 0, 0, 0), 6, 4, 16'h1100};
        tbl[1]  = '{mk(6'h00, 6'h23), 1'b0, d(0, 0, 0, 1, 0, 0, 0, 0, 0), 6, 4, 16'h1100};
        tbl[2]  = '{mk(6'h00, 6'h2a), 1'b0, d(0, 3, 0, 1, 0, 0, 0, 0, 0), 6, 4, 16'h1100};
        tbl[3]  = '{mk(6'h00, 6'h08), 1'b0, d(0, 0, 3, 0, 0, 0, 0, 0, 0), 8, 3, 16'h0200};
        tbl[4]  = '{mk(6'h0d, 6'h00), 1'b0, d(1, 0, 0, 2, 1, 0, 0, 0, 0), 6, 4, 16'h1100};
        tbl[5]  = '{mk(6'h0f, 6'h00), 1'b0, d(1, 0, 0, 0, 1, 2, 0, 0, 0), 6, 4, 16'h1100};
        tbl[6]  = '{mk(6'h08, 6'h00), 1'b0, d(1, 0, 0, 0, 1, 1, 1, 0, 0), 6, 4, 16'h1100};
        tbl[7]  = '{mk(6'h09, 6'h00), 1'b0, d(1, 0, 0, 0, 1, 1, 0, 0, 0), 6, 4, 16'h1100};
        tbl[8]  = '{mk(6'h04, 6'h00), 1'b1, d(0, 0, 1, 1, 0, 1, 0, 0, 0), 8, 3, 16'h0200};
        tbl[9]  = '{mk(6'h04, 6'h00), 1'b0, d(0, 0, 1, 1, 0, 1, 0, 0, 0), 8, 3, 16'h0100};
        tbl[10] = '{mk(6'h02, 6'h00), 1'b0, d(0, 0, 2, 0, 0, 0, 0, 0, 0), 9, 3, 16'h0200};
        tbl[11] = '{mk(6'h03, 6'h00), 1'b0, d(2, 2, 2, 0, 0, 0, 0, 0, 0), 9, 3, 16'h1200};
        tbl[12] = '{mk(6'h23, 6'h00), 1'b0, d(1, 1, 0, 0, 1, 1, 0, 0, 0), 2, 5, 16'h1110};
        tbl[13] = '{mk(6'h20, 6'h00), 1'b0, d(1, 1, 0, 0, 1, 1, 0, 1, 0), 2, 5, 16'h1110};
        tbl[14] = '{mk(6'h2b, 6'h00), 1'b0, d(0, 1, 0, 0, 1, 1, 0, 0, 0), 2, 4, 16'h0101};
        tbl[15] = '{mk(6'h28, 6'h00), 1'b0, d(0, 1, 0, 0, 1, 1, 0, 0, 1), 2, 4, 16'h0101};

        // Reset held across clock edges with ready inputs high: no strobes, nothing counts.
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", state, 4'd0);
        check("rst_stb", {irwr, pcwr, rf_we, mem_rd, memwr}, 5'b0);
        check("rst_cyc", cycle_cnt, 0);
        check("rst_ret", retired_cnt, 0);
        check("rst_trap", {trap, trap_cause}, 3'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 16; k++) begin
            run_seq(tbl[k].i, tbl[k].z, 0, n, stb, dec, s2);
            exp_cyc += tbl[k].lat;
            exp_ret++;
            check($sformatf("v%0d_dec", k), dec, tbl[k].dec);
            check($sformatf("v%0d_state2", k), s2, tbl[k].s2);
            check($sformatf("v%0d_lat", k), n, tbl[k].lat);
            check($sformatf("v%0d_strobes", k), stb, tbl[k].stb);
            check($sformatf("v%0d_end", k), state, 4'd0);
            check($sformatf("v%0d_ret", k), retired_cnt, exp_ret);
            check($sformatf("v%0d_cyc", k), cycle_cnt, exp_cyc);
        end

        run_seq(mk(6'h23, 6'h00), 1'b0, 3, n, stb, dec, s2);
        exp_cyc += 8;
        exp_ret++;
        check("lw_wait_lat", n, 8);
        check("lw_wait_strobes", stb, 16'h1140);
        check("lw_wait_ret", retired_cnt, exp_ret);
        check("lw_wait_cyc", cycle_cnt, exp_cyc);

        // Ready on the last allowed wait cycle must complete rather than trap.
        run_seq(mk(6'h2b, 6'h00), 1'b0, 3, n, stb, dec, s2);
        exp_cyc += 7;
        exp_ret++;
        check("sw_edge_lat", n, 7);
        check("sw_edge_strobes", stb, 16'h0104);
        check("sw_edge_state", state, 4'd0);
        check("sw_edge_trap", trap, 1'b0);
        check("sw_edge_ret", retired_cnt, exp_ret);

        instr = mk(6'h03, 6'h00);
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("jal_state", state, 4'd9);
        check("jal_wb", {rf_we, regdst, write_sel, pcwr}, 6'b1_10_10_1);
        @(negedge clk);
        #1;
        check("jal_end", state, 4'd0);
        instr = mk(6'h23, 6'h00);
        repeat (3) @(negedge clk);
        #1;
        check("lw_rd_state", state, 4'd3);
        check("lw_rd", mem_rd, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("abort_state", state, 4'd0);
        check("abort_stb", {irwr, pcwr, rf_we, mem_rd, memwr}, 5'b0);
        check("abort_ret", retired_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        exp_cyc = 0;
        exp_ret = 0;

        run_seq(mk(6'h2b, 6'h00), 1'b0, 100, n, stb, dec, s2);
        exp_cyc += 7;
        check("sw_to_lat", n, 7);
        check("sw_to_strobes", stb, 16'h0104);
        trap_then_reset("sw_to", 2'b10);

        run_seq(mk(6'h3f, 6'h00), 1'b0, 0, n, stb, dec, s2);
        exp_cyc += 2;
        check("ill_lat", n, 2);
        check("ill_strobes", stb, 16'h0100);
        check("ill_ret", retired_cnt, 0);
        trap_then_reset("ill", 2'b01);

        run_seq(tbl[0].i, 1'b0, 0, n, stb, dec, s2);
        check("resume_ret", retired_cnt, 1);
        check("resume_cyc", cycle_cnt, 4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passed, checks);
        $fatal(1);
    end
endmodule
